fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the RV32I core. Holds the fetch PC, issues word requests to instruction memory over a valid/ready handshake, and buffers in-order responses in a small FIFO. It presents `Instr` and its PC to decode, where the immediate is extracted and sign-extended. Branch and jump targets computed downstream (PC + ImmExt) return as a redirect, which flushes every in-flight and buffered instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `DEPTH`, default 2: instruction buffer entries, and the credit limit on buffered plus in-flight requests. Must be ≥1.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ImemReqValid` output 1: fetch request valid.
- `ImemReqReady` input 1: memory accepts the request.
- `ImemAddr` output 32: word address of the request, equal to the fetch PC.
- `ImemRspValid` input 1: response beat. Responses arrive in request order, at least 1 cycle after acceptance, and are always accepted.
- `ImemRspData` input 32: instruction word.
- `InstrValid` output 1: buffer head is valid.
- `InstrReady` input 1: decode consumes the head.
- `Instr` output 32: head instruction.
- `InstrPC` output 32: PC of the head instruction.
- `Redirect` input 1: branch or jump taken.
- `RedirectPC` input 32: new fetch target.
- `MisalignFault` output 1: sticky; a redirect target was not word-aligned.

## Operation
- **State:**
  - fetch PC `pc`.
  - FIFO of {instr, pc} with `count` in 0..DEPTH.
  - `inflight` counter of accepted requests with no response yet, width clog2(DEPTH+1).
  - `drop` counter, where drop ≤ inflight.
  - `fault` flag.
- **Request rule:** `ImemReqValid = !fault && !Redirect && (count + inflight < DEPTH)`. `ImemAddr = pc`.
- **On request handshake:** `pc <= pc + 4` (wraps modulo 2^32) and `inflight` increments.
- **On response:** `inflight` decrements.
  - If `drop > 0`: the response is discarded and `drop` decrements.
  - Otherwise `{ImemRspData, pc_of_request}` is pushed. A shadow issue-PC queue, or `pc - 4*inflight`, recovers the request PC.
  - A response while `inflight == 0` is a protocol violation and is ignored.
- **Dequeue:** happens when `InstrValid && InstrReady`. The head pops. Push and pop in the same cycle leave `count` unchanged.
- **Redirect (highest priority):**
  - FIFO cleared (`count <= 0`).
  - `drop <= inflight - (ImemRspValid ? 1 : 0)`. A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - `pc <= RedirectPC`.
  - A dequeue in the same cycle is still honoured by decode, but the FIFO ends empty.
- **Fault:** if `RedirectPC[1:0] != 0` during a redirect, `fault <= 1`.
  - The flush still occurs.
  - No further requests are issued.
  - In-flight responses are still drained via `drop`.
  - Only reset clears the fault.
- **Redirect while faulted:** further redirects still flush but do not clear the fault.

## Timing
- **Reset values (async assert):**
  - `pc = RESET_PC`.
  - `count = inflight = drop = 0`.
  - `MisalignFault = 0`, `InstrValid = 0`.
  - `Instr = 0`, `InstrPC = 0`.
  - `ImemReqValid = 0` while `rst_n` is low.
- **First request:** in the first rising edge after reset deasserts, `ImemReqValid = 1` with `ImemAddr = RESET_PC`.
- **Latency:** response in cycle t → `InstrValid` in cycle t+1 (registered FIFO, no bypass).
- **Back-to-back issue:** with DEPTH=2 and 1-cycle memory, one request per cycle is sustained as long as decode pops every cycle.
- **Reset mid-operation:** all state clears immediately. In-flight memory responses arriving after reset are ignored, because `inflight == 0`.
- **Combinational paths:** `ImemReqValid` depends combinationally on `Redirect`. All other outputs are registered.

## Test plan
- **Reset and stream:** RESET_PC=0x100, memory ready with 1-cycle latency, `InstrReady=1` → requests 0x100, 0x104, 0x108 on consecutive cycles. `Instr` and `InstrPC` follow 2 cycles after each request, in order.
- **Backpressure:** `InstrReady=0` → exactly DEPTH=2 requests issue, then `ImemReqValid` stays 0. Raising `InstrReady` drains 0x100 then 0x104, and fetch resumes at 0x108.
- **Redirect with in-flight:** 2-cycle memory, redirect to 0x200 while 2 requests are in flight → both responses are dropped. The first delivered instruction has `InstrPC=0x200`.
- **Redirect coincident with response:** `Redirect` and `ImemRspValid` in the same cycle → that response is dropped and `InstrValid` stays 0 the next cycle. The next request goes to the new target.
- **Misaligned target:** redirect to 0x202 → `MisalignFault=1` the next cycle, `ImemReqValid` stays 0 permanently, and `InstrValid` is 0. Asserting `rst_n` low clears the fault.
- **Memory stall:** `ImemReqReady=0` for 5 cycles → `ImemAddr` holds constant, and `pc` advances only on the handshake.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response, decode handoff and redirect signals of the fetch stage
interface fetch_unit_if;
  logic        ImemReqValid;
  logic        ImemReqReady;
  logic [31:0] ImemAddr;
  logic        ImemRspValid;
  logic [31:0] ImemRspData;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        MisalignFault;
  modport master (
    output ImemReqValid, ImemAddr, InstrValid, Instr, InstrPC, MisalignFault,
    input  ImemReqReady, ImemRspValid, ImemRspData, InstrReady, Redirect, RedirectPC
  );
  modport slave (
    input  ImemReqValid, ImemAddr, InstrValid, Instr, InstrPC, MisalignFault,
    output ImemReqReady, ImemRspValid, ImemRspData, InstrReady, Redirect, RedirectPC
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage with credit-limited imem requests and a flushable instruction FIFO
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] LIM = CW1'(DEPTH);
  logic [31:0]   pc_q, pc_d, rsp_pc;
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d, widx;
  logic          fault_q, fault_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   mem_d [DEPTH];
  logic          req_fire, rsp_ok, push, pop;
  assign bus.ImemReqValid  = rst_n && !fault_q && !bus.Redirect && ({1'b0, count_q} + {1'b0, inflight_q} < LIM);
  assign bus.ImemAddr      = pc_q;
  assign bus.InstrValid    = count_q != '0;
  assign bus.Instr         = mem_q[0][63:32];
  assign bus.InstrPC       = mem_q[0][31:0];
  assign bus.MisalignFault = fault_q;
  assign req_fire = bus.ImemReqValid && bus.ImemReqReady;
  assign rsp_ok   = bus.ImemRspValid && inflight_q != '0;
  assign push     = rsp_ok && drop_q == '0 && !bus.Redirect;
  assign pop      = bus.InstrValid && bus.InstrReady;
  assign widx     = count_q - CW'(pop);
  // Once drop reaches zero every outstanding request was issued from the current pc stream
  assign rsp_pc   = pc_q - (32'(inflight_q) << 2);
  always_comb begin
    pc_d       = bus.Redirect ? bus.RedirectPC : req_fire ? pc_q + 32'd4 : pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
    drop_d     = bus.Redirect ? inflight_q - CW'(rsp_ok) : drop_q - CW'(rsp_ok && drop_q != '0);
    count_d    = bus.Redirect ? '0 : count_q + CW'(push) - CW'(pop);
    fault_d    = fault_q || (bus.Redirect && bus.RedirectPC[1:0] != 2'b00);
  end
  // Shift-down FIFO keeps the head in entry 0 so Instr/InstrPC come straight from flops
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [63:0] up;
    if (i == DEPTH - 1) begin : g_last
      assign up = mem_q[i];
    end else begin : g_mid
      assign up = mem_q[i + 1];
    end
    assign mem_d[i] = (push && widx == CW'(i)) ? {bus.ImemRspData, rsp_pc} : pop ? up : mem_q[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      fault_q    <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      fault_q    <= fault_d;
      mem_q      <= mem_d;
    end
endmodule
